// File: rtl/sap1_pkg.sv
// SAP-1 controller shared definitions: opcodes, T-state one-hot codes,
// control-word layout (Cp..~Lo) and the idle control word.
package sap1_pkg;

    localparam int OP_W   = 4;
    localparam int RING_W = 6;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef struct packed {
        logic pc_inc;
        logic pc_oe;
        logic mar_low_ld;
        logic rom_low_oe;
        logic ir_low_ld;
        logic ir_low_oe;
        logic a_low_ld;
        logic a_oe;
        logic alu_sub;
        logic alu_oe;
        logic b_low_ld;
        logic out_low_ld;
    } ctrl_word_t;

    // Active-high fields 0, active-low fields 1.
    localparam ctrl_word_t CW_IDLE = ctrl_word_t'(12'h3E3);

    // Opcodes without an execute phase.
    function automatic logic is_nop(input logic [3:0] op);
        return !(op inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT});
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring. Ports: clk, rst (sync, high), hold (freeze),
// wrap (return to T1 early), ring (one-hot, bit0 = T1).
module sap1_ring_counter #(
    parameter int RING_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              wrap,
    output logic [RING_W-1:0] ring
);

    localparam logic [RING_W-1:0] FIRST = {{(RING_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            ring <= FIRST;
        end else if (hold) begin
            ring <= ring;
        end else if (wrap || ring[RING_W-1]) begin
            ring <= FIRST;
        end else begin
            ring <= {ring[RING_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: ring counter plus opcode decode into the
// 12-bit control word. Ports: clk, rst, run, ir_op in; control strobes,
// t_state, halted out. Define SAP1_VAR_CYCLE_EN for variable-length cycles.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int RING_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [OP_W-1:0]   ir_op,
    output logic              PC_INC,
    output logic              PC_OE,
    output logic              MAR_LOW_LD,
    output logic              ROM_LOW_OE,
    output logic              IR_LOW_LD,
    output logic              IR_LOW_OE,
    output logic              A_LOW_LD,
    output logic              A_OE,
    output logic              ALU_SUB,
    output logic              ALU_OE,
    output logic              B_LOW_LD,
    output logic              OUT_LOW_LD,
    output logic [RING_W-1:0] t_state,
    output logic              halted
);

    logic [RING_W-1:0] ring;
    logic              advance;
    logic              halt_now;
    logic              wrap;
    ctrl_word_t        cw;

    assign advance  = run && !halted;
    assign halt_now = advance && ring[3] && (ir_op == OP_HLT);

`ifdef SAP1_VAR_CYCLE_EN
    // The T3 decision sees the opcode presented during T3; it is the
    // caller's job to have the decoded opcode there for NOP skipping.
    always_comb begin
        wrap = 1'b0;
        if (ring[2] && is_nop(ir_op))
            wrap = 1'b1;
        if (ring[3] && (ir_op == OP_OUT))
            wrap = 1'b1;
        if (ring[4] && (ir_op == OP_LDA))
            wrap = 1'b1;
    end
`else
    assign wrap = 1'b0;
`endif

    sap1_ring_counter #(
        .RING_W (RING_W)
    ) u_ring (
        .clk  (clk),
        .rst  (rst),
        .hold (!advance || halt_now),
        .wrap (wrap),
        .ring (ring)
    );

    always_ff @(posedge clk) begin
        if (rst)
            halted <= 1'b0;
        else if (halt_now)
            halted <= 1'b1;
    end

    always_comb begin
        cw = CW_IDLE;
        if (!rst && advance) begin
            unique case (1'b1)
                ring[0]: begin
                    cw.pc_oe      = 1'b1;
                    cw.mar_low_ld = 1'b0;
                end
                ring[1]: begin
                    cw.pc_inc = 1'b1;
                end
                ring[2]: begin
                    cw.rom_low_oe = 1'b0;
                    cw.ir_low_ld  = 1'b0;
                end
                ring[3]: begin
                    case (ir_op)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw.ir_low_oe  = 1'b0;
                            cw.mar_low_ld = 1'b0;
                        end
                        OP_OUT: begin
                            cw.a_oe       = 1'b1;
                            cw.out_low_ld = 1'b0;
                        end
                        default: ;
                    endcase
                end
                ring[4]: begin
                    case (ir_op)
                        OP_LDA: begin
                            cw.rom_low_oe = 1'b0;
                            cw.a_low_ld   = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            cw.rom_low_oe = 1'b0;
                            cw.b_low_ld   = 1'b0;
                        end
                        default: ;
                    endcase
                end
                ring[5]: begin
                    if (ir_op == OP_ADD || ir_op == OP_SUB) begin
                        cw.alu_oe   = 1'b1;
                        cw.a_low_ld = 1'b0;
                        cw.alu_sub  = (ir_op == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign PC_INC     = cw.pc_inc;
    assign PC_OE      = cw.pc_oe;
    assign MAR_LOW_LD = cw.mar_low_ld;
    assign ROM_LOW_OE = cw.rom_low_oe;
    assign IR_LOW_LD  = cw.ir_low_ld;
    assign IR_LOW_OE  = cw.ir_low_oe;
    assign A_LOW_LD   = cw.a_low_ld;
    assign A_OE       = cw.a_oe;
    assign ALU_SUB    = cw.alu_sub;
    assign ALU_OE     = cw.alu_oe;
    assign B_LOW_LD   = cw.b_low_ld;
    assign OUT_LOW_LD = cw.out_low_ld;
    assign t_state    = ring;

endmodule

// File: tb/tb_sap1_controller.sv
// Testbench for sap1_controller: step-counter reference model plus a
// small SAP-1 datapath model running the LDA/ADD/OUT/HLT program.
module tb_sap1_controller;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] ir_op;
    logic       PC_INC, PC_OE, MAR_LOW_LD, ROM_LOW_OE, IR_LOW_LD, IR_LOW_OE;
    logic       A_LOW_LD, A_OE, ALU_SUB, ALU_OE, B_LOW_LD, OUT_LOW_LD;
    logic [5:0] t_state;
    logic       halted;

    sap1_controller dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .ir_op      (ir_op),
        .PC_INC     (PC_INC),
        .PC_OE      (PC_OE),
        .MAR_LOW_LD (MAR_LOW_LD),
        .ROM_LOW_OE (ROM_LOW_OE),
        .IR_LOW_LD  (IR_LOW_LD),
        .IR_LOW_OE  (IR_LOW_OE),
        .A_LOW_LD   (A_LOW_LD),
        .A_OE       (A_OE),
        .ALU_SUB    (ALU_SUB),
        .ALU_OE     (ALU_OE),
        .B_LOW_LD   (B_LOW_LD),
        .OUT_LOW_LD (OUT_LOW_LD),
        .t_state    (t_state),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam int CP = 11, EP = 10, LM = 9, CE = 8, LI = 7, EI = 6;
    localparam int LA = 5, EA = 4, SU = 3, EU = 2, LB = 1, LO = 0;
    localparam logic [11:0] LOW_MASK = 12'h3E3;

`ifdef SAP1_VAR_CYCLE_EN
    localparam int OUT_CYC  = 14;
    localparam int HALT_CYC = 19;
`else
    localparam int OUT_CYC  = 15;
    localparam int HALT_CYC = 22;
`endif

    int checks   = 0;
    int failures = 0;

    int          mk;
    bit          mh;
    bit          mvalid = 0;
    logic [11:0] s_cw;
    logic        s_halt;

    logic [7:0] rom [16];
    logic [3:0] pc, mar;
    logic [7:0] ir, a, b, outr;

    function automatic logic [11:0] exp_cw(input int k, input logic [3:0] op);
        logic [11:0] act;
        act = '0;
        case (k)
            1: begin act[EP] = 1; act[LM] = 1; end
            2: act[CP] = 1;
            3: begin act[CE] = 1; act[LI] = 1; end
            4: begin
                if (op <= 4'h2) begin act[EI] = 1; act[LM] = 1; end
                if (op == 4'hE) begin act[EA] = 1; act[LO] = 1; end
            end
            5: begin
                if (op == 4'h0) begin act[CE] = 1; act[LA] = 1; end
                if (op == 4'h1 || op == 4'h2) begin
                    act[CE] = 1;
                    act[LB] = 1;
                end
            end
            6: begin
                if (op == 4'h1 || op == 4'h2) begin
                    act[EU] = 1;
                    act[LA] = 1;
                    act[SU] = (op == 4'h2);
                end
            end
            default: ;
        endcase
        return act ^ LOW_MASK;
    endfunction

    function automatic int next_k(input int k, input logic [3:0] op);
`ifdef SAP1_VAR_CYCLE_EN
        if (k == 3 && !(op inside {4'h0, 4'h1, 4'h2, 4'hE, 4'hF}))
            return 1;
        if (k == 4 && op == 4'hE)
            return 1;
        if (k == 5 && op == 4'h0)
            return 1;
`endif
        return (k == 6) ? 1 : k + 1;
    endfunction

    task automatic tick(input logic r, input logic ru, input logic [3:0] op);
        logic [11:0] got, exp;
        logic [5:0]  ets;
        int          drv;
        rst   = r;
        run   = ru;
        ir_op = op;
        @(negedge clk);
        got = {PC_INC, PC_OE, MAR_LOW_LD, ROM_LOW_OE, IR_LOW_LD, IR_LOW_OE,
               A_LOW_LD, A_OE, ALU_SUB, ALU_OE, B_LOW_LD, OUT_LOW_LD};
        exp = (r || !ru || mh) ? LOW_MASK : exp_cw(mk, op);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL ctrl_word k=%0d op=%h rst=%b run=%b got=%h exp=%h",
                     mk, op, r, ru, got, exp);
        end
        ets = 6'b000001 << (mk - 1);
        checks++;
        if (t_state !== ets) begin
            failures++;
            $display("FAIL t_state got=%b exp=%b", t_state, ets);
        end
        checks++;
        if (halted !== mh) begin
            failures++;
            $display("FAIL halted got=%b exp=%b", halted, mh);
        end
        drv = int'(PC_OE) + int'(!ROM_LOW_OE) + int'(!IR_LOW_OE)
            + int'(A_OE) + int'(ALU_OE);
        checks++;
        if (drv > 1) begin
            failures++;
            $display("FAIL bus_drivers got=%0d exp<=1", drv);
        end
        s_cw   = got;
        s_halt = halted;
        @(posedge clk);
        if (r) begin
            mk = 1;
            mh = 0;
        end else if (ru && !mh) begin
            if (mk == 4 && op == 4'hF)
                mh = 1;
            else
                mk = next_k(mk, op);
        end
        #1;
    endtask

    task automatic dp_step();
        logic [7:0] bus;
        bus = 8'h00;
        if (s_cw[EP])
            bus = {4'h0, pc};
        else if (!s_cw[CE])
            bus = rom[mar];
        else if (!s_cw[EI])
            bus = {4'h0, ir[3:0]};
        else if (s_cw[EA])
            bus = a;
        else if (s_cw[EU])
            bus = s_cw[SU] ? a - b : a + b;
        if (!s_cw[LM]) mar = bus[3:0];
        if (!s_cw[LI]) ir = bus;
        if (!s_cw[LA]) a = bus;
        if (!s_cw[LB]) b = bus;
        if (!s_cw[LO]) outr = bus;
        if (s_cw[CP]) pc = pc + 4'd1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++)
            tick(1, 1, 4'h0);
        checks++;
        if (t_state !== 6'b000001) begin
            failures++;
            $display("FAIL reset_tstate got=%b exp=000001", t_state);
        end
    endtask

    task automatic test_program();
        int n_out;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h08;
        rom[1] = 8'h19;
        rom[2] = 8'hE0;
        rom[3] = 8'hF0;
        rom[8] = 8'h09;
        rom[9] = 8'h08;
        pc = 0; mar = 0; ir = 0; a = 0; b = 0; outr = 0;
        n_out = 0;
        tick(1, 1, 4'h0);
        for (int c = 0; c < 26; c++) begin
            tick(0, 1, ir[7:4]);
            if (!s_cw[LO]) n_out++;
            if (c == OUT_CYC) begin
                checks++;
                if (s_cw[LO] !== 1'b0 || a !== 8'h11) begin
                    failures++;
                    $display("FAIL prog_out cyc=%0d out_ld=%b a=%h exp 0,11",
                             c, s_cw[LO], a);
                end
            end
            if (c == HALT_CYC - 1 || c == HALT_CYC) begin
                checks++;
                if (s_halt !== (c == HALT_CYC)) begin
                    failures++;
                    $display("FAIL prog_halt cyc=%0d got=%b", c, s_halt);
                end
            end
            dp_step();
        end
        checks++;
        if (outr !== 8'h11 || n_out != 1) begin
            failures++;
            $display("FAIL prog_result out=%h loads=%0d exp 11,1", outr, n_out);
        end
    endtask

    task automatic test_sub();
        tick(1, 1, 4'h2);
        for (int i = 0; i < 6; i++) begin
            tick(0, 1, 4'h2);
            checks++;
            if (s_cw[SU] !== (i == 5) || s_cw[EU] !== (i == 5)) begin
                failures++;
                $display("FAIL sub_t%0d su=%b eu=%b", i + 1, s_cw[SU], s_cw[EU]);
            end
        end
    endtask

    task automatic test_run_hold();
        tick(1, 1, 4'h1);
        tick(0, 1, 4'h1);
        tick(0, 1, 4'h1);
        for (int i = 0; i < 3; i++)
            tick(0, 0, 4'h1);
        checks++;
        if (t_state !== 6'b000100) begin
            failures++;
            $display("FAIL hold_tstate got=%b exp=000100", t_state);
        end
        tick(0, 1, 4'h1);
        tick(0, 1, 4'h1);
    endtask

    task automatic test_nop();
        tick(1, 1, 4'h5);
        for (int i = 0; i < 12; i++)
            tick(0, 1, 4'h5);
    endtask

    task automatic test_reset_mid();
        tick(1, 1, 4'hF);
        for (int i = 0; i < 7; i++)
            tick(0, 1, 4'hF);
        tick(1, 1, 4'hF);
        for (int i = 0; i < 4; i++)
            tick(0, 1, 4'h1);
        tick(1, 1, 4'h1);
        tick(0, 1, 4'h1);
        checks++;
        if (s_cw[EP] !== 1'b1 || s_cw[LM] !== 1'b0) begin
            failures++;
            $display("FAIL restart_fetch got=%h", s_cw);
        end
    endtask

    task automatic test_random();
        logic       r, ru;
        logic [3:0] op;
        logic [3:0] pool [6];
        pool[0] = 4'h0; pool[1] = 4'h1; pool[2] = 4'h2;
        pool[3] = 4'hE; pool[4] = 4'hF; pool[5] = 4'h7;
        tick(1, 1, 4'h0);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            ru = ($urandom_range(0, 5) != 0);
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : pool[$urandom_range(0, 5)];
            tick(r, ru, op);
        end
    endtask

    initial begin
        rst   = 1'b1;
        run   = 1'b0;
        ir_op = 4'h0;
        @(posedge clk);
        #1;
        mk     = 1;
        mh     = 0;
        mvalid = 1;
        test_reset();
        test_program();
        test_sub();
        test_run_hold();
        test_nop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
